nibble_pair_packer: RTL and testbench
=====================================

# nibble_pair_packer

Assembles a valid/ready stream of 4-bit nibbles into 8-bit packed unsigned `pair_t` words (`lo` in bits [7:4], `hi` in bits [3:0]). It buffers the words in a small output FIFO. It is the writer-side counterpart of the logic that takes a byte apart into its `lo`/`hi` fields: nibbles 0xC then 0x8 produce word 8'hC8 (= 200). It sits between a nibble-wide producer and any byte-wide consumer of `pair_t`.

## Interface
- `DEPTH`, default 4: output FIFO entries; must be a power of two and ≥ 2.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `in_nibble` is valid.
- `in_ready`  out  1  nibble accepted this cycle when `in_valid && in_ready`.
- `in_nibble`  in  4  nibble data; the first nibble of a pair becomes `lo`, the second becomes `hi`.
- `flush`  in  1  level-sensitive request to complete a partial word with `hi` = 4'h0.
- `out_valid`  out  1  `out_data` holds the FIFO head.
- `out_ready`  in  1  head is popped when `out_valid && out_ready`.
- `out_data`  out  8  `pair_t` FIFO head, laid out as {lo, hi}.
- `level`  out  $clog2(DEPTH)+1  current number of FIFO entries.
- `partial`  out  1  a `lo` nibble is held and waiting for its `hi`.

## Operation
- Assembler FSM has two states:
  - EMPTY: no nibble held.
  - HALF: `lo` register holds the first nibble.
- Acceptance: `acc = in_valid && in_ready`.
- `space = (level != DEPTH)`. Registered level only; no same-cycle pop pass-through.
- `in_ready = (state == EMPTY && !flush) || space`.
- Transitions:
  - EMPTY, `acc`, `!flush`: `lo <= in_nibble`; go to HALF. No push.
  - EMPTY, `acc`, `flush`: push {in_nibble, 4'h0}; stay in EMPTY.
  - EMPTY, `flush`, no `acc`: no effect.
  - HALF, `acc`: push {lo, in_nibble}; go to EMPTY. A concurrent `flush` is absorbed and produces no extra word.
  - HALF, `flush`, no `acc`, `space`: push {lo, 4'h0}; go to EMPTY.
  - HALF, `flush`, `!space`: no action. `flush` must be held until `space`.
- FIFO:
  - Circular buffer with read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
  - `out_valid = (level != 0)`.
  - Push and pop in the same cycle leave `level` unchanged.
  - Push never occurs when full; pop never occurs when empty.
- `partial = (state == HALF)`.
- Arithmetic is unsigned throughout. `level` is never sign-extended and never exceeds DEPTH.

## Timing
- Reset values:
  - State EMPTY; `lo` = 0; pointers 0; `level` = 0.
  - `out_valid` = 0; `out_data` = 8'h00; `partial` = 0.
  - `in_ready` = 1, provided `flush` is low.
- Latency: a word completed at edge k appears as `out_valid = 1` with correct `out_data` in the cycle after edge k. Applies to empty FIFO, one cycle.
- `out_data` is stable while `out_valid && !out_ready`.
- Full FIFO in EMPTY state: one more nibble is still accepted (becomes `lo`, moves to HALF). The following nibble stalls until a pop lowers `level` at an edge.
- Reset mid-operation discards the held `lo` and all FIFO contents. No word is emitted for a partial pair.
- `in_ready` is combinational from `state`, `flush`, and `level` only. It has no dependence on `in_valid` or `out_ready`.

## Structure
- Package `pack_pkg`:
  - `typedef struct packed unsigned { bit [3:0] lo; bit [3:0] hi; } pair_t;`
  - Constants `NIBBLE_W = 4` and `WORD_W = 8`.
- Sub-module `pair_fifo` (parameter `DEPTH`; element type `pair_t`):
  - Ports: push, push_data, pop, head, level.
- Top level: FSM, `lo` register, handshake logic.

## Test plan
- Reset: hold `rst` for 2 cycles with `flush` = 0 → `out_valid` = 0, `out_data` = 8'h00, `level` = 0, `partial` = 0, `in_ready` = 1.
- Basic pack: nibbles 0xC then 0x8, `out_ready` = 1 → one word, `out_data` == 8'hC8 == 200, `.lo` == 4'hC, `.hi` == 4'h8, valid one cycle after the second acceptance.
- Flush:
  - Nibble 0xA, then `flush` one cycle → word 8'hA0, `partial` returns to 0.
  - `flush` while EMPTY with no nibble → no word.
- Simultaneous events: HALF holding `lo` = 0x5, then `flush` and nibble 0x3 in the same cycle → exactly one word, 8'h53; `level` increments by 1.
- Backpressure and wrap (`DEPTH` = 4, `out_ready` = 0):
  - Send nibbles 0..8 → `level` = 4, `partial` = 1, `in_ready` = 0.
  - Then `out_ready` = 1 → words 8'h01, 8'h23, 8'h45, 8'h67 in order, followed by 8'h8X once a 10th nibble X arrives.
  - Repeat for 3 full pointer wraps with no loss.
- Reset mid-operation: `lo` = 0xF held and 2 words in the FIFO, assert `rst` → `level` = 0, `out_valid` = 0, `partial` = 0. The next pair 0x1, 0x2 yields 8'h12.

Source files
------------

// File: rtl/pack_pkg.sv
// ---------------------------------------------------------------------------
// pack_pkg
//   Shared types and constants for the nibble pair packer and its output FIFO.
//
//   NIBBLE_W     : width of one input nibble
//   WORD_W       : width of one packed output word
//   pair_t       : packed word, lo nibble in [7:4], hi nibble in [3:0]
//   asm_state_t  : assembler states (EMPTY = nothing held, HALF = lo held)
//   make_pair    : builds a pair_t from two nibbles
// ---------------------------------------------------------------------------
package pack_pkg;

    localparam int NIBBLE_W = 4;
    localparam int WORD_W   = 8;

    typedef struct packed unsigned {
        bit [3:0] lo;
        bit [3:0] hi;
    } pair_t;

    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } asm_state_t;

    // Field order in the struct fixes the layout, so callers never have to
    // remember which nibble lands in the upper half of the byte.
    function automatic pair_t make_pair(input logic [3:0] lo_nib,
                                        input logic [3:0] hi_nib);
        pair_t p;
        p.lo = lo_nib;
        p.hi = hi_nib;
        return p;
    endfunction

endpackage

// File: rtl/pair_fifo.sv
// ---------------------------------------------------------------------------
// pair_fifo
//   Small circular-buffer FIFO of pair_t words. Head is shown combinationally
//   from the read pointer, so a word is visible the cycle after it is pushed.
//
//   Parameters:
//     DEPTH     : number of entries (power of two, >= 2)
//   Ports:
//     clk       : clock, all state changes on rising edge
//     rst       : synchronous active-high reset, empties the FIFO
//     push      : write push_data at the tail (caller guarantees not full)
//     push_data : word to write
//     pop       : drop the head entry (caller guarantees not empty)
//     head      : current head entry
//     level     : number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module pair_fifo
    import pack_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  pair_t                  push_data,
    input  logic                   pop,
    output pair_t                  head,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PW = $clog2(DEPTH);

    pair_t           mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;

    // Pointers are exactly log2(DEPTH) bits wide, so their natural overflow
    // is the modulo-DEPTH wrap. The level counter is kept separately so that
    // full and empty are unambiguous even when the pointers are equal.
    // Storage is cleared on reset so the head reads as zero until the first
    // push.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/nibble_pair_packer.sv
// ---------------------------------------------------------------------------
// nibble_pair_packer
//   Collects a valid/ready stream of nibbles into pair_t bytes: the first
//   nibble of a pair becomes lo, the second becomes hi. A flush request
//   completes a pending lo with hi = 0. Finished words are queued in a
//   pair_fifo and offered on a valid/ready output.
//
//   Parameters:
//     DEPTH     : output FIFO entries (power of two, >= 2)
//   Ports:
//     clk       : clock
//     rst       : synchronous active-high reset, drops held nibble and FIFO
//     in_valid  : in_nibble is valid
//     in_ready  : nibble accepted when in_valid && in_ready
//     in_nibble : input nibble
//     flush     : level request to finish a partial word with hi = 0
//     out_valid : out_data holds the FIFO head
//     out_ready : head popped when out_valid && out_ready
//     out_data  : FIFO head as {lo, hi}
//     level     : FIFO occupancy
//     partial   : a lo nibble is held waiting for its hi
// ---------------------------------------------------------------------------
module nibble_pair_packer
    import pack_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NIBBLE_W-1:0]    in_nibble,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_W-1:0]      out_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   partial
);

    localparam int              LW         = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0]   FULL_LEVEL = LW'(DEPTH);

    asm_state_t     state;
    logic [3:0]     lo;
    logic           acc;
    logic           space;
    logic           push;
    logic           pop;
    pair_t          push_data;
    pair_t          head;

    // Handshake and push decode. Space is judged on the registered level
    // only, so a pop in the same cycle never frees room early; that keeps
    // in_ready free of any path from out_ready. In EMPTY without flush a
    // nibble only fills lo, so it can be taken even when the FIFO is full.
    // In HALF a nibble always completes a word, which also swallows any
    // concurrent flush.
    always_comb begin
        space     = (level != FULL_LEVEL);
        in_ready  = ((state == EMPTY) && !flush) || space;
        acc       = in_valid && in_ready;
        pop       = out_valid && out_ready;
        push      = 1'b0;
        push_data = '0;
        case (state)
            EMPTY: begin
                if (acc && flush) begin
                    push      = 1'b1;
                    push_data = make_pair(in_nibble, 4'h0);
                end
            end
            HALF: begin
                if (acc) begin
                    push      = 1'b1;
                    push_data = make_pair(lo, in_nibble);
                end else if (flush && space) begin
                    push      = 1'b1;
                    push_data = make_pair(lo, 4'h0);
                end
            end
            default: begin
                push      = 1'b0;
                push_data = '0;
            end
        endcase
    end

    // Assembler state and the held lo nibble. A flush with the FIFO full
    // leaves HALF untouched; the producer keeps flush high until room opens.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            lo    <= 4'h0;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc && !flush) begin
                        lo    <= in_nibble;
                        state <= HALF;
                    end
                end
                HALF: begin
                    if (acc || (flush && space)) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    pair_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .level     (level)
    );

    assign out_valid = (level != '0);
    assign out_data  = head;
    assign partial   = (state == HALF);

endmodule

// File: tb/tb_nibble_pair_packer.sv
// ---------------------------------------------------------------------------
// tb_nibble_pair_packer
//   Self-checking bench for nibble_pair_packer with DEPTH = 4. Expected words
//   go into a scoreboard queue when the stimulus that creates them is driven;
//   a monitor compares each popped head against the queue front.
// ---------------------------------------------------------------------------
module tb_nibble_pair_packer;
    import pack_pkg::*;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_nibble;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] level;
    logic       partial;

    int         total;
    int         bad;
    logic [7:0] sbQueue [$];

    typedef struct {
        logic       v;
        logic [3:0] n;
        logic       f;
        logic       r;
        logic       pushW;
        logic [7:0] w;
        logic       expPartial;
        logic [2:0] expLevel;
        logic       expValid;
        logic [7:0] expData;
    } vec_t;

    vec_t vecs [10];

    nibble_pair_packer #(
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_nibble (in_nibble),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .partial   (partial)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Drive one table row, queue its word if it makes one, advance one edge
    task automatic applyStimulus(input vec_t vec);
        in_valid  = vec.v;
        in_nibble = vec.n;
        flush     = vec.f;
        out_ready = vec.r;
        if (vec.pushW) sbQueue.push_back(vec.w);
        @(posedge clk);
        #1;
    endtask

    // Offer a nibble until it is accepted, with a bounded wait
    task automatic sendNibble(input logic [3:0] n);
        int cnt;
        cnt       = 0;
        in_valid  = 1'b1;
        in_nibble = n;
        while (!in_ready && cnt < 50) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        checkOutput("accept_in_time", 32'(cnt < 50), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Let the output drain until the scoreboard is empty, with a bound
    task automatic drainAll();
        int cnt;
        cnt       = 0;
        out_ready = 1'b1;
        while ((sbQueue.size() != 0 || out_valid) && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        checkOutput("drain_in_time", 32'(cnt < 100), 32'd1);
        checkOutput("level_after_drain", 32'(level), 32'd0);
    endtask

    // Scoreboard monitor: every pop is compared with the oldest expected word
    always @(negedge clk) begin
        logic [7:0] exp;
        if (!rst && out_valid && out_ready) begin
            if (sbQueue.size() == 0) begin
                checkOutput("unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                exp = sbQueue.pop_front();
                checkOutput("popped_word", 32'(out_data), 32'(exp));
            end
        end
    end

    initial begin
        pair_t      p;
        logic [3:0] prev;
        logic [3:0] base;

        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_nibble = 4'h0;
        flush     = 1'b0;
        out_ready = 1'b0;

        //                v  n    f  r  push w      part lvl valid data
        vecs[0] = '{1'b1, 4'hC, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 4'h8, 1'b0, 1'b0, 1'b1, 8'hC8, 1'b0, 3'd1, 1'b1, 8'hC8};
        vecs[2] = '{1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 3'd1, 1'b1, 8'hC8};
        vecs[3] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 8'hA0, 1'b0, 3'd2, 1'b1, 8'hC8};
        vecs[4] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd2, 1'b1, 8'hC8};
        vecs[5] = '{1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 3'd2, 1'b1, 8'hC8};
        vecs[6] = '{1'b1, 4'h3, 1'b1, 1'b0, 1'b1, 8'h53, 1'b0, 3'd3, 1'b1, 8'hC8};
        vecs[7] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd2, 1'b1, 8'hA0};
        vecs[8] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd1, 1'b1, 8'h53};
        vecs[9] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00};

        // Reset held for two edges
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data",  32'(out_data),  32'h00);
        checkOutput("rst_level",     32'(level),     32'd0);
        checkOutput("rst_partial",   32'(partial),   32'd0);
        checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
        rst = 1'b0;

        // Basic pack, flush, idle flush, simultaneous flush+nibble, drain
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d_partial", i), 32'(partial), 32'(vecs[i].expPartial));
            checkOutput($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].expLevel));
            checkOutput($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].expValid));
            if (vecs[i].expValid) begin
                p = out_data;
                checkOutput($sformatf("vec%0d_head", i), 32'(out_data), 32'(vecs[i].expData));
                checkOutput($sformatf("vec%0d_head_lo", i), 32'(p.lo), 32'(vecs[i].expData[7:4]));
                checkOutput($sformatf("vec%0d_head_hi", i), 32'(p.hi), 32'(vecs[i].expData[3:0]));
            end
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;

        // Backpressure, full-FIFO stall and pointer wrap, three rounds
        for (int r = 0; r < 3; r++) begin
            base      = 4'(r * 3);
            out_ready = 1'b0;
            prev      = 4'h0;
            for (int i = 0; i < 8; i++) begin
                sendNibble(base + 4'(i));
                if (i % 2 == 1) sbQueue.push_back({prev, base + 4'(i)});
                prev = base + 4'(i);
            end
            sendNibble(base + 4'd8);
            checkOutput("full_level",    32'(level),    32'd4);
            checkOutput("full_partial",  32'(partial),  32'd1);
            checkOutput("full_in_ready", 32'(in_ready), 32'd0);
            in_valid  = 1'b1;
            in_nibble = base + 4'd9;
            repeat (3) begin
                @(posedge clk);
                #1;
                checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
                checkOutput("stall_level",    32'(level),    32'd4);
            end
            sbQueue.push_back({base + 4'd8, base + 4'd9});
            out_ready = 1'b1;
            sendNibble(base + 4'd9);
            drainAll();
            checkOutput("wrap_partial", 32'(partial), 32'd0);
        end

        // Reset in the middle of operation
        out_ready = 1'b0;
        sendNibble(4'h1);
        sendNibble(4'h2);
        sendNibble(4'h3);
        sendNibble(4'h4);
        sendNibble(4'hF);
        checkOutput("pre_rst_level",   32'(level),   32'd2);
        checkOutput("pre_rst_partial", 32'(partial), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        sbQueue.delete();
        checkOutput("mid_rst_level",     32'(level),     32'd0);
        checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_partial",   32'(partial),   32'd0);
        checkOutput("mid_rst_out_data",  32'(out_data),  32'h00);
        rst       = 1'b0;
        out_ready = 1'b1;
        sbQueue.push_back(8'h12);
        sendNibble(4'h1);
        sendNibble(4'h2);
        drainAll();

        checkOutput("scoreboard_empty", 32'(sbQueue.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
